seg_serial_rx: RTL and testbench

- Receive end of the four-wire serial seven-segment interface (SEGCLK, SEGDT, SEGCLR, SEGEN) that the Top CPU drives toward the board's shift-register display chain.
- Oversamples the four wires in the system clock domain and deserializes FRAME_BITS-bit frames, MSB first.
- Presents each completed frame with a one-cycle valid strobe; flags aborted or timed-out frames.
- Used as an on-board loopback monitor and as the bench-side checker for segment output, replacing waveform inspection of SEGDT.

---
 rtl/seg_if_pkg.sv | 25 ++
 rtl/seg_sync.sv | 33 +++
 rtl/seg_serial_rx.sv | 145 ++++++++++++++
 tb/tb_seg_serial_rx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg_if_pkg.sv
// Shared definitions for the serial seven-segment interface receiver.
package seg_if_pkg;

  localparam int SEG_FRAME_BITS  = 64;
  localparam int SEG_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  // Ceiling log2 used to size counters from parameters at elaboration time.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/seg_sync.sv
// Multi-flop synchronizer for one asynchronous input wire, with a selectable
// reset value so inactive-high signals come out of reset deasserted.
module seg_sync
  import seg_if_pkg::*;
#(
  parameter int   STAGES  = SEG_SYNC_STAGES,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_d;
  logic [STAGES-1:0] sync_q;

  // Shift the raw input one stage deeper each clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer chain register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/seg_serial_rx.sv
// Receive side of the SEGCLK/SEGDT/SEGCLR/SEGEN display link: oversamples the
// wires, deserializes MSB-first frames and strobes completed or aborted frames.
module seg_serial_rx
  import seg_if_pkg::*;
#(
  parameter int FRAME_BITS  = SEG_FRAME_BITS,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = SEG_SYNC_STAGES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            seg_clk,
  input  logic                            seg_dt,
  input  logic                            seg_clr,
  input  logic                            seg_en,
  output logic [FRAME_BITS-1:0]           frame,
  output logic                            frame_valid,
  output logic                            frame_err,
  output logic                            disp_on,
  output logic [clog2(FRAME_BITS):0]      bit_cnt
);

  localparam int                CNT_W    = clog2(FRAME_BITS) + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT - 1);

  logic clk_s, dt_s, clr_s, en_s;

  seg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (.clk(clk), .rst(rst), .d(seg_clk), .q(clk_s));
  seg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dt  (.clk(clk), .rst(rst), .d(seg_dt),  .q(dt_s));
  seg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clr (.clk(clk), .rst(rst), .d(seg_clr), .q(clr_s));
  seg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_en  (.clk(clk), .rst(rst), .d(seg_en),  .q(en_s));

  rx_state_e             state_d, state_q;
  logic                  prev_q;
  logic [CNT_W-1:0]      bit_cnt_d, bit_cnt_q;
  logic [FRAME_BITS-1:0] shift_d, shift_q;
  logic [FRAME_BITS-1:0] frame_d, frame_q;
  logic [15:0]           timer_d, timer_q;
  logic                  valid_d, valid_q;
  logic                  err_d, err_q;

  logic                  rise;
  logic                  clear;
  logic                  complete;
  logic                  timeout;
  logic [FRAME_BITS-1:0] shifted;

  // Event decode: a full frame is handed off in the cycle after its last bit,
  // and a rise in the timeout cycle still counts as data.
  always_comb begin
    rise     = clk_s & ~prev_q;
    clear    = ~clr_s;
    complete = (state_q == RECV) && (bit_cnt_q == CNT_FULL);
    timeout  = (state_q == RECV) && !complete && !rise && (timer_q == TMO_LAST);
    shifted  = {shift_q[FRAME_BITS-2:0], dt_s};
  end

  // State register and all datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_q    <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      frame_q   <= '0;
      timer_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= clk_s;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      frame_q   <= frame_d;
      timer_q   <= timer_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: clear dominates, a completed frame re-arms, timeout aborts.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (complete) begin
      state_d = rise ? RECV : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise) state_d = RECV;
        RECV:    if (timeout) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and strobe logic driven by the current state and decoded events.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    frame_d   = frame_q;
    timer_d   = timer_q;
    // A completed frame always reports valid, even if clear arrives with it.
    valid_d   = complete;
    err_d     = 1'b0;

    if (clear) begin
      shift_d   = '0;
      bit_cnt_d = '0;
      timer_d   = '0;
      // Only a genuinely partial frame is reported as discarded; after the first
      // low cycle bit_cnt is already 0, so this fires once per clear.
      err_d     = (bit_cnt_q != '0) && !complete;
    end else if (rise && (state_q == IDLE || complete)) begin
      shift_d   = {{(FRAME_BITS-1){1'b0}}, dt_s};
      bit_cnt_d = CNT_W'(1);
      timer_d   = '0;
    end else if (complete || state_q == IDLE) begin
      bit_cnt_d = '0;
      timer_d   = '0;
    end else if (rise) begin
      shift_d   = shifted;
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      timer_d   = '0;
      if (bit_cnt_q == CNT_LAST) frame_d = shifted;
    end else if (timeout) begin
      shift_d   = '0;
      bit_cnt_d = '0;
      timer_d   = '0;
      err_d     = 1'b1;
    end else begin
      timer_d   = timer_q + 16'd1;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign disp_on     = en_s;
  assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_seg_serial_rx.sv
// Directed-plus-random bench for seg_serial_rx with a frame-level reference.
module tb_seg_serial_rx;

  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        seg_clk, seg_dt, seg_clr, seg_en;
  logic [63:0] frame;
  logic        frame_valid, frame_err, disp_on;
  logic [6:0]  bit_cnt;

  seg_serial_rx #(.FRAME_BITS(64), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .seg_clk(seg_clk), .seg_dt(seg_dt), .seg_clr(seg_clr),
    .seg_en(seg_en), .frame(frame), .frame_valid(frame_valid), .frame_err(frame_err),
    .disp_on(disp_on), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Monitor bookkeeping, sampled on the falling edge.
  int          vcount = 0, ecount = 0, both_cnt = 0;
  int          valid_cyc = 0, err_cyc = 0, last_rise_cyc = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] last_good = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        vcount++;
        valid_cyc = cyc;
        got_q.push_back(frame);
      end
      if (frame_err) begin
        ecount++;
        err_cyc = cyc;
      end
      if (frame_valid && frame_err) both_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bit at 10 clk cycles: 5 low with data set up, then 5 high.
  task automatic send_bit(input logic b);
    seg_dt  = b;
    seg_clk = 1'b0;
    tick(5);
    seg_clk = 1'b1;
    last_rise_cyc = cyc;
    tick(5);
  endtask

  task automatic send_frame(input logic [63:0] v);
    for (int i = 63; i >= 0; i--) send_bit(v[i]);
    exp_q.push_back(v);
    last_good = v;
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_frame"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int          v0, e0;
    logic [63:0] v;

    rst = 1'b1; seg_clk = 1'b0; seg_dt = 1'b0; seg_clr = 1'b1; seg_en = 1'b0;
    tick(3);
    check("rst_frame", frame, 64'h0);
    check("rst_valid", 64'(frame_valid), 64'h0);
    check("rst_err", 64'(frame_err), 64'h0);
    check("rst_disp", 64'(disp_on), 64'h0);
    check("rst_bitcnt", 64'(bit_cnt), 64'h0);
    rst = 1'b0;
    tick(3);

    // Full frame, plus latency: driven rise after edge E is synchronized by
    // E+2, captured at E+3 and strobed from E+4.
    v0 = vcount;
    send_frame(64'hF0E1_D2C3_B4A5_9687);
    check("full_vcount", 64'(vcount - v0), 64'd1);
    check("full_latency", 64'(valid_cyc - last_rise_cyc), 64'd4);
    check("full_frame", frame, 64'hF0E1_D2C3_B4A5_9687);
    check("full_bitcnt", 64'(bit_cnt), 64'h0);
    check_frames("full");

    // Timeout: timer runs 0..TIMEOUT-1 from the capture edge E+3.
    e0 = ecount;
    for (int i = 0; i < 20; i++) send_bit(1'($urandom));
    check("tmo_midcnt", 64'(bit_cnt), 64'd20);
    seg_clk = 1'b0;
    tick(1100);
    check("tmo_ecount", 64'(ecount - e0), 64'd1);
    check("tmo_when", 64'(err_cyc - last_rise_cyc), 64'(TIMEOUT + 3));
    check("tmo_frame", frame, last_good);
    check("tmo_bitcnt", 64'(bit_cnt), 64'h0);

    // Clear mid-frame, then an all-ones frame.
    e0 = ecount;
    for (int i = 0; i < 30; i++) send_bit(1'($urandom));
    seg_clr = 1'b0;
    tick(5);
    check("clr_bitcnt", 64'(bit_cnt), 64'h0);
    check("clr_frame", frame, last_good);
    seg_clr = 1'b1;
    tick(4);
    check("clr_ecount", 64'(ecount - e0), 64'd1);
    send_frame(64'hFFFF_FFFF_FFFF_FFFF);
    check("clr_ecount_after", 64'(ecount - e0), 64'd1);
    check_frames("clr");

    // Back-to-back frames with no gap.
    v0 = vcount;
    send_frame(64'h0123_4567_89AB_CDEF);
    send_frame(~64'h0123_4567_89AB_CDEF);
    check("b2b_vcount", 64'(vcount - v0), 64'd2);
    check_frames("b2b");

    // Asynchronous reset between clock edges after 40 bits.
    for (int i = 0; i < 40; i++) send_bit(1'($urandom));
    v0 = vcount; e0 = ecount;
    #2 rst = 1'b1;
    #2;
    check("amid_frame", frame, 64'h0);
    check("amid_bitcnt", 64'(bit_cnt), 64'h0);
    check("amid_valid", 64'(frame_valid), 64'h0);
    check("amid_err", 64'(frame_err), 64'h0);
    tick(3);
    rst = 1'b0;
    seg_clk = 1'b0;
    tick(3);
    send_frame(64'hA5A5_A5A5_A5A5_A5A5);
    check("arst_strobes", 64'(ecount - e0), 64'd0);
    check_frames("arst");

    // Enable toggled mid-frame: two-cycle sync delay, reception unaffected.
    v = {$urandom, $urandom};
    for (int i = 63; i >= 0; i--) begin
      send_bit(v[i]);
      if (i == 40 || i == 20) begin
        seg_en = (i == 40);
        tick(1);
        check("en_delay1", 64'(disp_on), 64'(i != 40));
        tick(1);
        check("en_delay2", 64'(disp_on), 64'(i == 40));
      end
    end
    exp_q.push_back(v);
    last_good = v;
    check_frames("en");

    // Random frames.
    for (int k = 0; k < 3; k++) send_frame({$urandom, $urandom});
    check_frames("rand");

    check("never_both", 64'(both_cnt), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
